m_ptw_mem_port: RTL

- Memory-side sequencer for the page walker.
- Turns the walker's PTE address and access strobes (pte_addr, acs, pte_we, pte_wdata, pw_state) into single-word DRAM read and write transactions.
- Returns the PTE word and busy flag in the form the walker expects: it samples odata in the first cycle busy is low.
- Sits between the MMU and the DRAM arbiter.
- Includes a watchdog so a stuck DRAM yields an invalid PTE (page fault) rather than a hang.

---
 rtl/m_ptw_mem_port_pkg.sv | 26 ++
 rtl/m_ptw_mem_port_if.sv | 23 ++
 rtl/m_ptw_mem_port_watchdog.sv | 22 ++
 rtl/m_ptw_mem_port.sv | 127 ++++++++++++
 4 files changed

// File: rtl/m_ptw_mem_port_pkg.sv
// Shared encodings for the page-walker memory port: walker states and port FSM states.
package m_ptw_mem_port_pkg;

   localparam logic [2:0] PW_IDLE = 3'd0;
   localparam logic [2:0] PW_L1   = 3'd1;
   localparam logic [2:0] PW_L1W  = 3'd2;
   localparam logic [2:0] PW_L0   = 3'd3;
   localparam logic [2:0] PW_CHK  = 3'd4;
   localparam logic [2:0] PW_UPD  = 3'd5;
   localparam logic [2:0] PW_HIT  = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_RD_DONE = 3'd3,
      ST_WR_REQ  = 3'd4
   } port_st_e;

   // A read starts on the walker's first cycle in an L1 or L0 fetch state.
   function automatic logic rd_trig_f(input logic [2:0] pw, input logic [2:0] prev_pw);
      return ((pw == PW_L1) && (prev_pw == PW_IDLE)) ||
             ((pw == PW_L0) && (prev_pw == PW_L1W));
   endfunction

endpackage

// File: rtl/m_ptw_mem_port_if.sv
// DRAM-side request/response bus of the page-walker memory port.
interface m_ptw_mem_port_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  o_dram_req;
   logic                  o_dram_we;
   logic [ADDR_WIDTH-1:0] o_dram_addr;
   logic [DATA_WIDTH-1:0] o_dram_wdata;
   logic                  i_dram_ack;
   logic                  i_dram_rvalid;
   logic [DATA_WIDTH-1:0] i_dram_rdata;

   modport master (
      output o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata,
      input  i_dram_ack, i_dram_rvalid, i_dram_rdata
   );

   modport slave (
      input  o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata,
      output i_dram_ack, i_dram_rvalid, i_dram_rdata
   );
endinterface

// File: rtl/m_ptw_mem_port_watchdog.sv
// Transaction watchdog: counts busy cycles and flags the last allowed one.
module m_ptw_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic CLK,
   input  logic RST_X,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   logic [7:0] cnt_q;

   // Count busy cycles; saturate so a stuck counter never wraps back to zero.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X)                    cnt_q <= 8'd0;
      else if (clr_i)                cnt_q <= 8'd0;
      else if (en_i && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
   end

   // Request has been outstanding TIMEOUT_CYCLES cycles at the end of this one.
   assign expired_o = en_i && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/m_ptw_mem_port.sv
// Page-walker memory port: turns walker PTE strobes into single-word DRAM reads/writes.
module m_ptw_mem_port
   import m_ptw_mem_port_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  CLK,
   input  logic                  RST_X,
   input  logic [2:0]            w_pw_state,
   input  logic [ADDR_WIDTH-1:0] w_tlb_pte_addr,
   input  logic                  w_tlb_acs,
   input  logic                  w_pte_we,
   input  logic [DATA_WIDTH-1:0] w_pte_wdata,
   output logic                  w_dram_busy,
   output logic [DATA_WIDTH-1:0] w_dram_odata,
   output logic                  o_timeout_err,
   m_ptw_mem_port_if.master      dram
);
   port_st_e              state_q, state_d;
   logic [2:0]            r_prev_pw_q;
   logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
   logic [DATA_WIDTH-1:0] r_wdata_q, r_wdata_d;
   logic [DATA_WIDTH-1:0] odata_q, odata_d;
   logic                  err_q, err_d;
   logic                  rd_trig, wd_en, wd_clr, wd_expired;

   assign rd_trig = rd_trig_f(w_pw_state, r_prev_pw_q);
   assign wd_en   = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT) || (state_q == ST_WR_REQ);
   assign wd_clr  = (state_q == ST_IDLE);

   m_ptw_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
      .CLK       (CLK),
      .RST_X     (RST_X),
      .clr_i     (wd_clr),
      .en_i      (wd_en),
      .expired_o (wd_expired)
   );

   // State and datapath registers.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         state_q     <= ST_IDLE;
         r_prev_pw_q <= 3'd0;
         r_addr_q    <= '0;
         r_wdata_q   <= '0;
         odata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_prev_pw_q <= w_pw_state;
         r_addr_q    <= r_addr_d;
         r_wdata_q   <= r_wdata_d;
         odata_q     <= odata_d;
         err_q       <= err_d;
      end
   end

   // Next-state logic; ack/rvalid beat a coincident watchdog expiry.
   always_comb begin
      state_d   = state_q;
      r_addr_d  = r_addr_q;
      r_wdata_d = r_wdata_q;
      odata_d   = odata_q;
      err_d     = err_q;
      case (state_q)
         ST_IDLE: begin
            if (w_tlb_acs) r_addr_d = w_tlb_pte_addr;
            if (w_pte_we) begin
               // Write wins a collision with a read trigger, which is flagged.
               r_addr_d  = w_tlb_pte_addr;
               r_wdata_d = w_pte_wdata;
               state_d   = ST_WR_REQ;
               if (rd_trig) err_d = 1'b1;
            end else if (rd_trig) begin
               state_d = ST_RD_REQ;
            end
         end
         ST_RD_REQ: begin
            if (dram.i_dram_ack) begin
               if (dram.i_dram_rvalid) begin
                  odata_d = dram.i_dram_rdata;
                  state_d = ST_RD_DONE;
               end else begin
                  state_d = ST_RD_WAIT;
               end
            end else if (wd_expired) begin
               odata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RD_DONE;
            end
         end
         ST_RD_WAIT: begin
            if (dram.i_dram_rvalid) begin
               odata_d = dram.i_dram_rdata;
               state_d = ST_RD_DONE;
            end else if (wd_expired) begin
               odata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RD_DONE;
            end
         end
         ST_RD_DONE: state_d = ST_IDLE;
         ST_WR_REQ: begin
            if (dram.i_dram_ack) begin
               state_d = ST_IDLE;
            end else if (wd_expired) begin
               odata_d = '0;
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Busy covers the trigger cycle itself so the walker never sees stale data.
   assign w_dram_busy  = wd_en || ((state_q == ST_IDLE) && rd_trig);
   assign w_dram_odata = odata_q;
   assign o_timeout_err = err_q;

   assign dram.o_dram_req   = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
   assign dram.o_dram_we    = (state_q == ST_WR_REQ);
   assign dram.o_dram_addr  = {r_addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign dram.o_dram_wdata = r_wdata_q;
endmodule
